// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port, shared by the ALU and LSU, plus an in-flight scoreboard for decode.
// Define REGFILE_WB_BYPASS_EN to add forwarding outputs (rs_fwd/rs2_fwd with data) on top of the pending flags.
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs_pending,
  output logic                  rs2_pending
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic                  rs_fwd,
  output logic [XLEN-1:0]       rs_fwd_data,
  output logic                  rs2_fwd,
  output logic [XLEN-1:0]       rs2_fwd_data
`endif
);

  typedef enum logic {EMPTY, FULL} buf_state_t;

  buf_state_t alu_state, alu_state_next;
  buf_state_t lsu_state, lsu_state_next;
  logic [REG_ADDR_W-1:0] alu_rd_q, lsu_rd_q;
  logic [XLEN-1:0]       alu_data_q, lsu_data_q;
  logic                  lsu_first, lsu_first_next;

  logic alu_full, lsu_full;
  logic grant_alu, grant_lsu;
  logic alu_fill, lsu_fill;

  assign alu_full = (alu_state == FULL);
  assign lsu_full = (lsu_state == FULL);

  // lsu_first marks the LSU buffer as the older one whenever both are full.
  assign grant_alu = alu_full && (!lsu_full || !lsu_first);
  assign grant_lsu = lsu_full && (!alu_full || lsu_first);

  assign alu_ready = !rst && (!alu_full || grant_alu);
  assign lsu_ready = !rst && (!lsu_full || grant_lsu);

  // Writes to x0 complete the handshake but never occupy a buffer.
  assign alu_fill = alu_valid && alu_ready && (alu_rd != '0);
  assign lsu_fill = lsu_valid && lsu_ready && (lsu_rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_state <= EMPTY;
      lsu_state <= EMPTY;
      lsu_first <= 1'b0;
    end else begin
      alu_state <= alu_state_next;
      lsu_state <= lsu_state_next;
      lsu_first <= lsu_first_next;
    end
  end

  always_comb begin
    alu_state_next = alu_state;
    lsu_state_next = lsu_state;
    lsu_first_next = lsu_first;
    if (alu_fill)       alu_state_next = FULL;
    else if (grant_alu) alu_state_next = EMPTY;
    if (lsu_fill)       lsu_state_next = FULL;
    else if (grant_lsu) lsu_state_next = EMPTY;
    // Same-cycle accepts order the LSU first; otherwise a surviving entry is older than a new one.
    if (alu_fill && lsu_fill)
      lsu_first_next = 1'b1;
    else if (alu_fill && lsu_state_next == FULL)
      lsu_first_next = 1'b1;
    else if (lsu_fill && alu_state_next == FULL)
      lsu_first_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_rd_q   <= '0;
      alu_data_q <= '0;
      lsu_rd_q   <= '0;
      lsu_data_q <= '0;
    end else begin
      if (alu_fill) begin
        alu_rd_q   <= alu_rd;
        alu_data_q <= alu_data;
      end
      if (lsu_fill) begin
        lsu_rd_q   <= lsu_rd;
        lsu_data_q <= lsu_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= grant_alu || grant_lsu;
      if (grant_lsu) begin
        rf_rd    <= lsu_rd_q;
        rf_wdata <= lsu_data_q;
      end else if (grant_alu) begin
        rf_rd    <= alu_rd_q;
        rf_wdata <= alu_data_q;
      end
    end
  end

  function automatic logic in_flight(input logic [REG_ADDR_W-1:0] r);
    return (r != '0) &&
           ((alu_full && alu_rd_q == r) ||
            (lsu_full && lsu_rd_q == r) ||
            (rf_we && rf_rd == r));
  endfunction

  assign rs_pending  = in_flight(rs);
  assign rs2_pending = in_flight(rs2);

`ifdef REGFILE_WB_BYPASS_EN
  // The write stage always holds the oldest entry, so buffers take priority, younger first.
  function automatic logic [XLEN-1:0] newest_value(input logic [REG_ADDR_W-1:0] r);
    logic alu_hit;
    logic lsu_hit;
    alu_hit = alu_full && (alu_rd_q == r);
    lsu_hit = lsu_full && (lsu_rd_q == r);
    if (lsu_first) begin
      if (alu_hit)      return alu_data_q;
      else if (lsu_hit) return lsu_data_q;
      else              return rf_wdata;
    end else begin
      if (lsu_hit)      return lsu_data_q;
      else if (alu_hit) return alu_data_q;
      else              return rf_wdata;
    end
  endfunction

  assign rs_fwd       = rs_pending;
  assign rs2_fwd      = rs2_pending;
  assign rs_fwd_data  = newest_value(rs);
  assign rs2_fwd_data = newest_value(rs2);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue model of acceptance order predicts writes, ready and pending.
// Define REGFILE_WB_BYPASS_EN to also check the forwarding outputs.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            alu_valid = 1'b0, lsu_valid = 1'b0;
  logic            alu_ready, lsu_ready;
  logic [AW-1:0]   alu_rd = '0, lsu_rd = '0, rs = '0, rs2 = '0;
  logic [XLEN-1:0] alu_data = '0, lsu_data = '0;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            rs_pending, rs2_pending;
`ifdef REGFILE_WB_BYPASS_EN
  logic            rs_fwd, rs2_fwd;
  logic [XLEN-1:0] rs_fwd_data, rs2_fwd_data;
`endif

  regfile_wb_arbiter #(.XLEN(XLEN), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .rs(rs), .rs2(rs2), .rs_pending(rs_pending), .rs2_pending(rs2_pending)
`ifdef REGFILE_WB_BYPASS_EN
    , .rs_fwd(rs_fwd), .rs_fwd_data(rs_fwd_data), .rs2_fwd(rs2_fwd), .rs2_fwd_data(rs2_fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit              lsu;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_t;

  // pend_q: accepted writes not yet issued, in acceptance order; exp_q: scoreboard of writes still to appear.
  wb_t             pend_q[$];
  wb_t             exp_q[$];
  bit              ws_valid = 1'b0;
  logic [AW-1:0]   ws_rd = '0;
  logic [XLEN-1:0] ws_data = '0;
  bit              started = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                               input bit lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ld,
                               input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    @(posedge clk);
    #2;
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld; rs = r1; rs2 = r2;
  endtask

  // A requester can hand over a new write unless it already has one waiting behind the head.
  function automatic bit model_ready(input bit lsu);
    if (rst) return 1'b0;
    foreach (pend_q[i]) if (pend_q[i].lsu == lsu && i != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_pending(input logic [AW-1:0] r);
    if (r == 0) return 1'b0;
    if (ws_valid && ws_rd == r) return 1'b1;
    foreach (pend_q[i]) if (pend_q[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] model_newest(input logic [AW-1:0] r);
    for (int i = pend_q.size() - 1; i >= 0; i--) if (pend_q[i].rd == r) return pend_q[i].data;
    return ws_data;
  endfunction

  // Reference model: one write issues per cycle from the head; accepts append LSU before ALU.
  always @(posedge clk) begin
    bit  ar, lr;
    wb_t e;
    ar = model_ready(1'b0);
    lr = model_ready(1'b1);
    started = 1'b1;
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
      ws_valid = 1'b0;
    end else begin
      ws_valid = 1'b0;
      if (pend_q.size() > 0) begin
        ws_valid = 1'b1;
        ws_rd    = pend_q[0].rd;
        ws_data  = pend_q[0].data;
        void'(pend_q.pop_front());
      end
      if (lsu_valid && lr && lsu_rd != 0) begin
        e = '{lsu: 1'b1, rd: lsu_rd, data: lsu_data};
        pend_q.push_back(e);
        exp_q.push_back(e);
      end
      if (alu_valid && ar && alu_rd != 0) begin
        e = '{lsu: 1'b0, rd: alu_rd, data: alu_data};
        pend_q.push_back(e);
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compares every DUT output against the model away from the active edge.
  always @(negedge clk) begin
    wb_t e;
    if (started) begin
      checkOutput("alu_ready", alu_ready, model_ready(1'b0));
      checkOutput("lsu_ready", lsu_ready, model_ready(1'b1));
      checkOutput("rf_we", rf_we, ws_valid);
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write actual rd=%0d data=%0h expected none", rf_rd, rf_wdata);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rf_rd", rf_rd, e.rd);
          checkOutput("rf_wdata", rf_wdata, e.data);
        end
      end
      checkOutput("rs_pending", rs_pending, model_pending(rs));
      checkOutput("rs2_pending", rs2_pending, model_pending(rs2));
`ifdef REGFILE_WB_BYPASS_EN
      checkOutput("rs_fwd", rs_fwd, model_pending(rs));
      checkOutput("rs2_fwd", rs2_fwd, model_pending(rs2));
      if (model_pending(rs))  checkOutput("rs_fwd_data", rs_fwd_data, model_newest(rs));
      if (model_pending(rs2)) checkOutput("rs2_fwd_data", rs2_fwd_data, model_newest(rs2));
`endif
    end
  end

  initial begin
    // Reset held three cycles with an ALU request present.
    rst = 1'b1; alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h55;
    repeat (3) applyStimulus(1, 1, 5'd9, 32'h55, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_rf_rd", rf_rd, 0);
    checkOutput("reset_rf_wdata", rf_wdata, 0);

    // Single ALU write with rs watching it.
    applyStimulus(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 5'd5, 0);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd5, 0);

    // Same-cycle accept to the same register.
    applyStimulus(0, 1, 5'd3, 32'h1, 1, 5'd3, 32'h2, 5'd3, 0);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd3, 0);

    // x0 write is swallowed.
    applyStimulus(0, 0, 0, 0, 1, 5'd0, 32'h1234, 5'd0, 5'd0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd0, 0);

    // Back-to-back ALU stream.
    for (int i = 1; i <= 8; i++)
      applyStimulus(0, 1, AW'(i), $urandom, 0, 0, 0, AW'(i), 5'd8);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ALU then LSU to the same register one cycle apart.
    applyStimulus(0, 1, 5'd7, 32'hA, 0, 0, 0, 5'd7, 0);
    applyStimulus(0, 0, 0, 0, 1, 5'd7, 32'hB, 5'd7, 0);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd7, 0);

    // Random traffic on a small register range, with one mid-run reset.
    for (int i = 0; i < 400; i++)
      applyStimulus(i == 200, ($urandom_range(0, 9) < 6), AW'($urandom_range(0, 7)), $urandom,
                    ($urandom_range(0, 9) < 6), AW'($urandom_range(0, 7)), $urandom,
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("drain_outstanding", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: ALU and load/store unit (LSU).
- Each requester has a valid/ready handshake and a one-entry holding buffer. Buffers drain oldest-first into a registered write stage that drives the register file.
- Also acts as a scoreboard: reports whether the register-file read addresses rs/rs2 have a writeback still in flight, for decode-stage hazard stalls.

Parameters:
- XLEN, 32, data width of register values.
- REG_ADDR_W, 5, register index width (32 architectural registers).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU writeback request.
- alu_ready  output  1  ALU request accepted this cycle when alu_valid && alu_ready.
- alu_rd  input  REG_ADDR_W  ALU destination register.
- alu_data  input  XLEN  ALU result.
- lsu_valid  input  1  LSU writeback request.
- lsu_ready  output  1  LSU request accepted this cycle when lsu_valid && lsu_ready.
- lsu_rd  input  REG_ADDR_W  LSU destination register.
- lsu_data  input  XLEN  load data.
- rf_we  output  1  register-file write enable (registered).
- rf_rd  output  REG_ADDR_W  register-file write address (registered).
- rf_wdata  output  XLEN  register-file write data (registered).
- rs  input  REG_ADDR_W  read address 1 from decode.
- rs2  input  REG_ADDR_W  read address 2 from decode.
- rs_pending  output  1  writeback to rs still in flight.
- rs2_pending  output  1  writeback to rs2 still in flight.

Behaviour:
- Reset:
  - Both buffers empty; age tracking cleared.
  - rf_we=0, rf_rd=0, rf_wdata=0.
  - alu_ready=lsu_ready=0 while rst is high; both rise to 1 the first cycle after rst deasserts.
- Buffer state per requester (ALU, LSU): full flag, rd, data, age tag. Each buffer is effectively a 2-state FSM: EMPTY or FULL.
  - EMPTY→FULL on accept.
  - FULL→EMPTY when granted, or FULL→FULL when granted and accepting a new request in the same cycle.
- Ready: xxx_ready = !full || granted_this_cycle (combinational). A requester sustains one transfer per cycle while it is the only requester.
- x0 writes: a request with rd==0 is accepted (ready rules as above), then discarded. It never fills a buffer and never produces rf_we.
- Arbitration, evaluated each cycle over full buffers:
  - One full buffer: it is granted.
  - Both full: the older (earlier-accepted) buffer is granted.
  - Both accepted in the same cycle: LSU is treated as older and is granted first; ALU is granted the following cycle.
  - Oldest-first precludes starvation. Same-rd writes from both requesters reach the register file in acceptance order.
- Write stage: on a grant, at the next edge rf_we=1, rf_rd=buffer rd, rf_wdata=buffer data. With no grant, rf_we=0 and rf_rd/rf_wdata hold their previous values.
- Latency: accept at edge N → buffer full in cycle N+1 → rf_we high in cycle N+2 (minimum, no contention). Maximum under contention: +1 cycle.
- Pending (combinational from registered state): rs_pending=1 iff rs!=0 and (either buffer is full with rd==rs, or rf_we=1 with rf_rd==rs). rs2_pending uses the identical rule on rs2. The register file is written at the end of the rf_we cycle, so pending stays high through that cycle.
- Requests arriving on the accept cycle are not yet in a buffer. Decode must not rely on pending for same-cycle accepts.
- Reset mid-operation: buffered, unissued writes are dropped; no rf_we is produced after rst is sampled high.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: adds outputs rs_fwd (1), rs_fwd_data (XLEN), rs2_fwd (1), rs2_fwd_data (XLEN).
  - rs_fwd=rs_pending. rs_fwd_data is the value that will be architecturally visible last, taken from the youngest source in order: younger full buffer, older full buffer, write stage.
  - Decode uses the forwarded value instead of stalling.
- Undefined: these ports do not exist; the pending outputs only are used to stall.

Test Plan:
- Reset: hold rst 3 cycles with alu_valid=1 → rf_we=0, both ready=0 during rst; ready=1 the cycle after release.
- Single ALU write rd=5, data=0xDEADBEEF, accepted at edge N → rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF in cycle N+2 only; rs=5 gives rs_pending=1 in N+1 and N+2, 0 in N+3.
- Same-cycle accept: ALU rd=3 data=1 and LSU rd=3 data=2 → LSU write (rd=3, data=2) first, then ALU (rd=3, data=1) next cycle; lsu_ready stays 1, alu_ready=0 for one cycle.
- x0 discard: LSU rd=0 data=0x1234 → accepted, rf_we never asserted; rs=0 gives rs_pending=0 throughout.
- Back-to-back ALU-only stream of 8 writes rd=1..8 → 8 consecutive rf_we cycles, one per cycle, in order; alu_ready held 1.
- Bypass (REGFILE_WB_BYPASS_EN): ALU rd=7 data=0xA, then LSU rd=7 data=0xB one cycle later, rs=7 → rs_fwd_data=0xB once both are pending; after both drain, rs_fwd=0.
